// File: rtl/fighter_action_fsm_if.sv
// Signal bundle between the keyboard/vsync front end and the fighter action FSM.
// Handshake: frame_tick is a one-Clk strobe with no ready/backpressure, keys are levels,
// and every output is a level that holds until the next frame_tick or reset.
interface fighter_action_fsm_if;
    logic       frame_tick;
    logic       punch_key;
    logic       jump_key;
    logic       punch;
    logic       jump;
    logic [7:0] jump_offset;
    logic       busy;
    logic [1:0] punch_state;
    logic [1:0] jump_state;

    modport master (
        output frame_tick, punch_key, jump_key,
        input  punch, jump, jump_offset, busy, punch_state, jump_state
    );

    modport slave (
        input  frame_tick, punch_key, jump_key,
        output punch, jump, jump_offset, busy, punch_state, jump_state
    );
endinterface

// File: rtl/fighter_action_fsm.sv
// Turns punch/jump key levels into frame-timed punch/jump flags and a jump height.
// Punch and jump are independent sub-FSMs; both advance only on frame_tick.
module fighter_action_fsm #(
    parameter int PUNCH_FRAMES    = 8,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int JUMP_HEIGHT     = 32,
    parameter int JUMP_STEP       = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    fighter_action_fsm_if.slave  bus
);

    localparam int CNT_MAX = (PUNCH_FRAMES > COOLDOWN_FRAMES) ? PUNCH_FRAMES : COOLDOWN_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PUNCH_LAST = CW'(PUNCH_FRAMES - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [7:0]    STEP_B     = 8'(JUMP_STEP);
    localparam logic [7:0]    HEIGHT_B   = 8'(JUMP_HEIGHT);

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_ACTIVE = 2'd1,
        P_COOL   = 2'd2
    } p_state_t;

    typedef enum logic [1:0] {
        J_GROUND = 2'd0,
        J_RISE   = 2'd1,
        J_FALL   = 2'd2
    } j_state_t;

    p_state_t      p_state, p_state_d;
    j_state_t      j_state, j_state_d;
    logic [CW-1:0] pcnt, pcnt_d;
    logic          punch_q, punch_d;
    logic          jump_q, jump_d;
    logic [7:0]    offset_q, offset_d;
    logic          punch_req, punch_req_d;
    logic          jump_req, jump_req_d;
    logic          pkey_q, jkey_q;
    logic          punch_press, jump_press;
    logic [7:0]    offset_up, offset_dn;

    assign punch_press = bus.punch_key & ~pkey_q;
    assign jump_press  = bus.jump_key  & ~jkey_q;
    assign offset_up   = offset_q + STEP_B;
    assign offset_dn   = offset_q - STEP_B;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            p_state   <= P_IDLE;
            j_state   <= J_GROUND;
            pcnt      <= '0;
            punch_q   <= 1'b0;
            jump_q    <= 1'b0;
            offset_q  <= 8'd0;
            punch_req <= 1'b0;
            jump_req  <= 1'b0;
            // Keys held through reset must not look like a fresh press.
            pkey_q    <= 1'b1;
            jkey_q    <= 1'b1;
        end else begin
            p_state   <= p_state_d;
            j_state   <= j_state_d;
            pcnt      <= pcnt_d;
            punch_q   <= punch_d;
            jump_q    <= jump_d;
            offset_q  <= offset_d;
            punch_req <= punch_req_d;
            jump_req  <= jump_req_d;
            pkey_q    <= bus.punch_key;
            jkey_q    <= bus.jump_key;
        end
    end

    // Punch: request latch plus ACTIVE/COOL frame counter.
    always_comb begin
        p_state_d   = p_state;
        pcnt_d      = pcnt;
        punch_d     = punch_q;
        punch_req_d = punch_req;
        if (punch_press && p_state == P_IDLE) begin
            punch_req_d = 1'b1;
        end
        if (bus.frame_tick) begin
            case (p_state)
                P_IDLE: begin
                    // Only a request latched before this tick can start the punch.
                    if (punch_req) begin
                        p_state_d   = P_ACTIVE;
                        punch_d     = 1'b1;
                        pcnt_d      = PUNCH_LAST;
                        punch_req_d = 1'b0;
                    end
                end
                P_ACTIVE: begin
                    if (pcnt == '0) begin
                        p_state_d = P_COOL;
                        punch_d   = 1'b0;
                        pcnt_d    = COOL_LAST;
                    end else begin
                        pcnt_d = pcnt - CNT_ONE;
                    end
                end
                P_COOL: begin
                    if (pcnt == '0) begin
                        p_state_d = P_IDLE;
                    end else begin
                        pcnt_d = pcnt - CNT_ONE;
                    end
                end
                default: begin
                    p_state_d = P_IDLE;
                    punch_d   = 1'b0;
                    pcnt_d    = '0;
                end
            endcase
        end
    end

    // Jump: symmetric rise/fall arc in JUMP_STEP increments.
    always_comb begin
        j_state_d  = j_state;
        jump_d     = jump_q;
        offset_d   = offset_q;
        jump_req_d = jump_req;
        if (jump_press && j_state == J_GROUND) begin
            jump_req_d = 1'b1;
        end
        if (bus.frame_tick) begin
            case (j_state)
                J_GROUND: begin
                    if (jump_req) begin
                        // A one-step arc peaks immediately and goes straight to falling.
                        j_state_d  = (STEP_B == HEIGHT_B) ? J_FALL : J_RISE;
                        jump_d     = 1'b1;
                        offset_d   = STEP_B;
                        jump_req_d = 1'b0;
                    end
                end
                J_RISE: begin
                    offset_d = offset_up;
                    if (offset_up == HEIGHT_B) begin
                        j_state_d = J_FALL;
                    end
                end
                J_FALL: begin
                    offset_d = offset_dn;
                    if (offset_dn == 8'd0) begin
                        j_state_d = J_GROUND;
                        jump_d    = 1'b0;
                    end
                end
                default: begin
                    j_state_d = J_GROUND;
                    jump_d    = 1'b0;
                    offset_d  = 8'd0;
                end
            endcase
        end
    end

    assign bus.punch       = punch_q;
    assign bus.jump        = jump_q;
    assign bus.jump_offset = offset_q;
    assign bus.busy        = (p_state != P_IDLE) || (j_state != J_GROUND);
    assign bus.punch_state = p_state;
    assign bus.jump_state  = j_state;

endmodule

// File: tb/tb_fighter_action_fsm.sv
// Directed bench for fighter_action_fsm: a vector table for punch timing plus
// hand-written sequences for the jump arc, overlap, reset and tick-coincident presses.
module tb_fighter_action_fsm;

    localparam int PUNCH_FRAMES    = 8;
    localparam int COOLDOWN_FRAMES = 4;
    localparam int JUMP_HEIGHT     = 32;
    localparam int JUMP_STEP       = 4;
    localparam int N_UP            = JUMP_HEIGHT / JUMP_STEP;
    localparam int AIR_TICKS       = 2 * N_UP;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    fighter_action_fsm_if bus ();

    fighter_action_fsm #(
        .PUNCH_FRAMES    (PUNCH_FRAMES),
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES),
        .JUMP_HEIGHT     (JUMP_HEIGHT),
        .JUMP_STEP       (JUMP_STEP)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       tick;
        logic       pk;
        logic       jk;
        logic       e_punch;
        logic       e_jump;
        logic [7:0] e_off;
        logic       e_busy;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic t, input logic p, input logic j);
        @(negedge Clk);
        bus.frame_tick = t;
        bus.punch_key  = p;
        bus.jump_key   = j;
        @(posedge Clk);
        #1;
    endtask

    task automatic check1(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic ep, input logic ej,
                             input logic [7:0] eo, input logic eb);
        check1({nm, ".punch"}, {7'd0, bus.punch}, {7'd0, ep});
        check1({nm, ".jump"}, {7'd0, bus.jump}, {7'd0, ej});
        check1({nm, ".offset"}, bus.jump_offset, eo);
        check1({nm, ".busy"}, {7'd0, bus.busy}, {7'd0, eb});
    endtask

    function automatic logic [7:0] arc(input int k);
        return 8'((k <= N_UP) ? k * JUMP_STEP : (AIR_TICKS - k) * JUMP_STEP);
    endfunction

    function automatic void add(input logic t, input logic p, input logic j, input logic ep,
                                input logic ej, input logic [7:0] eo, input logic eb,
                                input string tag);
        vec_t v;
        v.tick = t; v.pk = p; v.jk = j;
        v.e_punch = ep; v.e_jump = ej; v.e_off = eo; v.e_busy = eb;
        v.tag = tag;
        vecs.push_back(v);
    endfunction

    // Ticks k0..end of a punch+jump started together, then one quiet tick.
    task automatic run_both(input string tag, input int k0);
        for (int k = k0; k <= AIR_TICKS; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check_all($sformatf("%s_k%0d", tag, k), k <= PUNCH_FRAMES, k < AIR_TICKS, arc(k),
                      (k <= PUNCH_FRAMES + COOLDOWN_FRAMES) || (k < AIR_TICKS));
        end
        step(1'b1, 1'b0, 1'b0);
        check_all({tag, "_done"}, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        // Punch timing table: press, 13 ticks with dropped presses in ACTIVE and COOL,
        // a quiet tick, then a second accepted punch.
        for (int r = 0; r < 2; r++) begin
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, $sformatf("p%0d_press", r));
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, $sformatf("p%0d_release", r));
            for (int k = 1; k <= PUNCH_FRAMES + COOLDOWN_FRAMES + 1; k++) begin
                logic ep, eb;
                ep = (k <= PUNCH_FRAMES);
                eb = (k <= PUNCH_FRAMES + COOLDOWN_FRAMES);
                add(1'b1, 1'b0, 1'b0, ep, 1'b0, 8'd0, eb, $sformatf("p%0d_tick%0d", r, k));
                if (r == 0 && (k == 3 || k == PUNCH_FRAMES + 2)) begin
                    add(1'b0, 1'b1, 1'b0, ep, 1'b0, 8'd0, eb, $sformatf("p_drop_press%0d", k));
                    add(1'b0, 1'b0, 1'b0, ep, 1'b0, 8'd0, eb, $sformatf("p_drop_rel%0d", k));
                end
            end
            add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, $sformatf("p%0d_quiet", r));
        end

        // Reset held with keys high and ticks running, then released with keys still high.
        bus.frame_tick = 1'b0;
        bus.punch_key  = 1'b1;
        bus.jump_key   = 1'b1;
        Reset_n        = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check_all("rst_hold", 1'b0, 1'b0, 8'd0, 1'b0);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b1);
            check_all($sformatf("rst_keys_high%0d", i), 1'b0, 1'b0, 8'd0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0);
        check_all("rst_keys_low", 1'b0, 1'b0, 8'd0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].tick, vecs[i].pk, vecs[i].jk);
            check_all(vecs[i].tag, vecs[i].e_punch, vecs[i].e_jump, vecs[i].e_off, vecs[i].e_busy);
        end

        // Jump arc with a mid-air re-press that must be ignored.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= AIR_TICKS; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check_all($sformatf("j_arc%0d", k), 1'b0, k < AIR_TICKS, arc(k), k < AIR_TICKS);
            if (k == 3) begin
                step(1'b0, 1'b0, 1'b1);
                check_all("j_midair_press", 1'b0, 1'b1, arc(k), 1'b1);
                step(1'b0, 1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        check_all("j_after", 1'b0, 1'b0, 8'd0, 1'b0);

        // Both keys pressed in the same cycle.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run_both("both", 1);

        // Reset in mid-jump with punch active; a tick during reset is ignored.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b1, 1'b0, 1'b0);
        check_all("r_pre", 1'b1, 1'b1, 8'd20, 1'b1);
        Reset_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check_all("r_mid", 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_all("r_tick_in_rst", 1'b0, 1'b0, 8'd0, 1'b0);
        Reset_n = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_all("r_nostart", 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        run_both("r_again", 1);

        // Press coincident with a tick is honoured one tick later.
        step(1'b1, 1'b1, 1'b1);
        check_all("c_tickN", 1'b0, 1'b0, 8'd0, 1'b0);
        run_both("c_tickN1", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
